// File: rtl/sha3_src_reader.sv
// SHA-3 input-side control FSM: pops a length header and message words from the
// source FIFO, issues datapath load strobes, inserts pad slots and hands rate blocks on.
module sha3_src_reader #(
  parameter int W          = 64,
  parameter int RATE_WORDS = 17,
  parameter int LEN_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src_ready,
  output logic         src_read,
  input  logic [W-1:0] din,
  output logic         ein,
  output logic         sel_pad,
  output logic         pad_first,
  output logic         pad_last,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ack,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  localparam logic [7:0] LAST_IDX = 8'(RATE_WORDS - 1);

  state_t               state_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [7:0]           widx_q;
  logic                 padded_q;
  logic                 pad_seen_q;
  logic                 blast_q;

  logic rem_zero, last_slot;
  logic src_read_c, ein_c, sel_pad_c, pad_first_c, pad_last_c;
  logic block_valid_c, block_last_c, busy_c;

  assign rem_zero  = (rem_q == '0);
  assign last_slot = (widx_q == LAST_IDX);

  // Only the word-count field of the header is meaningful.
  generate
    if (W > LEN_WIDTH) begin : g_din_unused
      logic unused_din;
      assign unused_din = ^din[W-1:LEN_WIDTH];
    end
  endgenerate

  always_comb begin
    src_read_c    = 1'b0;
    ein_c         = 1'b0;
    sel_pad_c     = 1'b0;
    pad_first_c   = 1'b0;
    pad_last_c    = 1'b0;
    block_valid_c = 1'b0;
    block_last_c  = 1'b0;
    busy_c        = (state_q != IDLE);
    case (state_q)
      IDLE: src_read_c = ~src_ready;
      LOAD: begin
        if (!rem_zero) begin
          src_read_c = ~src_ready;
          ein_c      = ~src_ready;
        end else begin
          ein_c       = 1'b1;
          sel_pad_c   = 1'b1;
          pad_first_c = ~pad_seen_q;
          pad_last_c  = last_slot;
        end
      end
      WAIT: begin
        block_valid_c = 1'b1;
        block_last_c  = blast_q;
      end
      default: ;
    endcase
  end

  // Reset overrides every output in the same cycle, whatever the state.
  assign src_read    = src_read_c    & ~rst;
  assign ein         = ein_c         & ~rst;
  assign sel_pad     = sel_pad_c     & ~rst;
  assign pad_first   = pad_first_c   & ~rst;
  assign pad_last    = pad_last_c    & ~rst;
  assign block_valid = block_valid_c & ~rst;
  assign block_last  = block_last_c  & ~rst;
  assign busy        = busy_c        & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      widx_q     <= '0;
      padded_q   <= 1'b0;
      pad_seen_q <= 1'b0;
      blast_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!src_ready) begin
          rem_q      <= din[LEN_WIDTH-1:0];
          widx_q     <= '0;
          padded_q   <= 1'b0;
          pad_seen_q <= 1'b0;
          state_q    <= LOAD;
        end
        LOAD: if (ein_c) begin
          if (rem_zero) begin
            padded_q   <= 1'b1;
            pad_seen_q <= 1'b1;
          end else begin
            rem_q <= rem_q - 1'b1;
          end
          // A block is final exactly when it holds at least one pad slot.
          if (last_slot) begin
            widx_q  <= '0;
            blast_q <= padded_q | rem_zero;
            state_q <= WAIT;
          end else begin
            widx_q <= widx_q + 8'd1;
          end
        end
        WAIT: if (block_ack) begin
          if (blast_q) begin
            state_q <= IDLE;
          end else begin
            padded_q <= 1'b0;
            state_q  <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
